// File: rtl/gpio_unit.sv
//==============================================================================
// Module   : gpio_unit
// Brief    : CSR-mapped GPIO block with a registered output and a synchronized,
//            optionally debounced input (enabled by macro GPIO_DEBOUNCE_EN).
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module gpio_unit #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [11:0] IO_IN_ADDR      = 12'hF00,
  parameter logic [11:0] IO_OUT_ADDR     = 12'hF02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gpio_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        in_changed
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("gpio_unit: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [31:0] r_gpio_out;
  logic [31:0] r_sync1;
  logic [31:0] r_sync2;
  logic [31:0] r_stable;
  logic        r_in_changed;
  logic        w_out_wr;

  assign w_out_wr = gpio_we && (csr_addr == IO_OUT_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_out <= '0;
    end else if (w_out_wr) begin
      r_gpio_out <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int             CW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [31:0]   r_cand;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt < C_CNT_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Acceptance looks only at the count already reached, so it is evaluated
  // independently of a candidate reload happening on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable     <= '0;
      r_in_changed <= 1'b0;
    end else if ((r_cnt == C_CNT_MAX) && (r_cand != r_stable)) begin
      r_stable     <= r_cand;
      r_in_changed <= 1'b1;
    end else begin
      r_in_changed <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable     <= '0;
      r_in_changed <= 1'b0;
    end else begin
      r_stable     <= r_sync2;
      r_in_changed <= (r_sync2 != r_stable);
    end
  end
`endif

  always_comb begin
    rdata = 32'h0;
    if (csr_addr == IO_IN_ADDR) begin
      rdata = r_stable;
    end else if (csr_addr == IO_OUT_ADDR) begin
      rdata = r_gpio_out;
    end
  end

  assign gpio_out   = r_gpio_out;
  assign in_changed = r_in_changed;

endmodule

`default_nettype wire
